// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [3:0] HPROT_RESET = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_e;

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for an incrementing burst, plus a flag when the new
// address starts a fresh 1KB region (and so must restart with NONSEQ).
module ahb_addr_gen #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    output logic [AW-1:0] next_addr,
    output logic          cross_1k
);

    assign next_addr = addr + (AW'(1) << size);
    assign cross_1k  = (next_addr[9:0] == 10'd0);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: turns command requests into pipelined
// NONSEQ/SEQ transfers, streaming write data in and read data out.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 2,
    parameter int LW = 8
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [LW-1:0] cmd_len,
    input  logic [3:0]    cmd_prot,
    input  logic [DW-1:0] wr_data,
    output logic          wr_pop,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          done,
    output logic          done_err,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [3:0]    hprot,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic [RW-1:0] hresp
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    state_e        state_q, state_d;
    htrans_e       htrans_q, htrans_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [2:0]    hburst_q, hburst_d;
    logic [3:0]    hprot_q, hprot_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic [LW-1:0] addr_left_q, addr_left_d;
    logic          data_act_q, data_act_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_last_q, rd_last_d;
    logic          done_q, done_d;
    logic          done_err_q, done_err_d;

    logic [AW-1:0] next_addr;
    logic          cross_1k;
    logic          addr_acc;
    logic          resp_err;

    ahb_addr_gen #(.AW(AW)) u_addr_gen (
        .addr      (haddr_q),
        .size      (hsize_q),
        .next_addr (next_addr),
        .cross_1k  (cross_1k)
    );

    assign addr_acc = hready && (htrans_q == HTRANS_NONSEQ || htrans_q == HTRANS_SEQ);
    assign resp_err = (hresp == RW'(HRESP_ERROR));

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hprot_d     = hprot_q;
        hwdata_d    = hwdata_q;
        addr_left_d = addr_left_q;
        data_act_d  = data_act_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_last_d   = 1'b0;
        done_d      = 1'b0;
        done_err_d  = 1'b0;
        wr_pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                data_act_d = 1'b0;
                if (cmd_valid) begin
                    if (cmd_size > MAX_SIZE) begin
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d     = ST_ADDR;
                        htrans_d    = HTRANS_NONSEQ;
                        haddr_d     = cmd_addr;
                        hwrite_d    = cmd_write;
                        hsize_d     = cmd_size;
                        hburst_d    = (cmd_len != '0) ? HBURST_INCR : HBURST_SINGLE;
                        hprot_d     = cmd_prot;
                        addr_left_d = cmd_len;
                    end
                end
            end

            ST_ADDR, ST_DATA: begin
                if (data_act_q && resp_err) begin
                    // ERROR cancels any pending address phase immediately
                    htrans_d = HTRANS_IDLE;
                    if (hready) begin
                        data_act_d = 1'b0;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    if (data_act_q && hready) begin
                        data_act_d = 1'b0;
                        if (!hwrite_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = hrdata;
                            rd_last_d  = (state_q == ST_DATA);
                        end
                        if (state_q == ST_DATA) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    if (addr_acc) begin
                        data_act_d = 1'b1;
                        wr_pop     = hwrite_q;
                        if (hwrite_q) begin
                            hwdata_d = wr_data;
                        end
                        if (addr_left_q == '0) begin
                            htrans_d = HTRANS_IDLE;
                            state_d  = ST_DATA;
                        end else begin
                            haddr_d     = next_addr;
                            htrans_d    = cross_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
                            addr_left_d = addr_left_q - LW'(1);
                        end
                    end
                end
            end

            ST_ERR: begin
                if (hready) begin
                    data_act_d = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= HBURST_SINGLE;
            hprot_q     <= HPROT_RESET;
            hwdata_q    <= '0;
            addr_left_q <= '0;
            data_act_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            hwdata_q    <= hwdata_d;
            addr_left_q <= addr_left_d;
            data_act_q  <= data_act_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hprot     = hprot_q;
    assign hwdata    = hwdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign done_err  = done_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small AHB slave model
// (wait states, ERROR injection, write memory, address-pattern read data).
module tb_ahb_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 2;
    localparam int LW = 8;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [LW-1:0] cmd_len;
    logic [3:0]    cmd_prot;
    logic [DW-1:0] wr_data;
    logic          wr_pop, rd_valid, rd_last, done, done_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata, hrdata;
    logic          hready;
    logic [RW-1:0] hresp;

    always #5 hclk = ~hclk;

    ahb_lite_master #(.AW(AW), .DW(DW), .RW(RW), .LW(LW)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_prot(cmd_prot),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_err(done_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          ws = 0;
    int          err_beat = 0;
    logic        hready_s, err_phase, dp_act, dp_write;
    logic [1:0]  hresp_s;
    logic [9:0]  dp_idx;
    int          wcnt, beat_no;
    logic [31:0] mem [0:1023];

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hready_s <= 1'b1; hresp_s <= 2'b00; err_phase <= 1'b0;
            dp_act <= 1'b0; dp_write <= 1'b0; dp_idx <= '0; wcnt <= 0; beat_no <= 0;
        end else begin
            if (cmd_ready) beat_no <= 0;
            if (hready_s) begin
                if (dp_act && dp_write && hresp_s == 2'b00) mem[dp_idx] <= hwdata;
                if (htrans[1]) begin
                    dp_act <= 1'b1; dp_write <= hwrite; dp_idx <= haddr[11:2];
                    beat_no <= beat_no + 1;
                    if (beat_no + 1 == err_beat) begin
                        hready_s <= 1'b0; hresp_s <= 2'b01; err_phase <= 1'b1;
                    end else if (ws > 0) begin
                        hready_s <= 1'b0; hresp_s <= 2'b00; wcnt <= ws - 1;
                    end else begin
                        hready_s <= 1'b1; hresp_s <= 2'b00;
                    end
                end else begin
                    dp_act <= 1'b0; hready_s <= 1'b1; hresp_s <= 2'b00;
                end
            end else if (err_phase) begin
                hready_s <= 1'b1; err_phase <= 1'b0;
            end else if (wcnt > 0) begin
                wcnt <= wcnt - 1;
            end else begin
                hready_s <= 1'b1;
            end
        end
    end

    assign hready = hready_s;
    assign hresp  = hresp_s;
    assign hrdata = dp_act ? (32'h5A00_0000 ^ {20'd0, dp_idx, 2'b00}) : 32'd0;

    // ---------------- show-ahead write stream ----------------
    int          wr_idx = 0;
    int          wr_base = 0;
    logic [31:0] wr_seed = 32'd0;

    always @(posedge hclk) if (hresetn && wr_pop) wr_idx <= wr_idx + 1;
    assign wr_data = wr_seed + 32'(wr_idx - wr_base);

    // ---------------- bus monitor ----------------
    logic [31:0] acc_addr_q[$];
    logic [1:0]  acc_trans_q[$];
    logic [31:0] rd_q[$];
    logic        rdl_q[$];
    int          done_cnt = 0, err_cnt = 0, unstable_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [80:0] prev_ctl;
    logic [80:0] cur_ctl;

    always @(negedge hclk) begin
        cur_ctl = {haddr, htrans, hwrite, hsize, hburst, hprot, hwdata};
        if (hresetn) begin
            if (hready && htrans[1]) begin
                acc_addr_q.push_back(haddr);
                acc_trans_q.push_back(htrans);
            end
            if (rd_valid) begin
                rd_q.push_back(rd_data);
                rdl_q.push_back(rd_last);
            end
            if (done) begin
                done_cnt++;
                if (done_err) err_cnt++;
            end
            if (prev_wait && cur_ctl != prev_ctl) unstable_cnt++;
            prev_wait = !hready && hresp == 2'b00;
        end else begin
            prev_wait = 1'b0;
        end
        prev_ctl = cur_ctl;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge hclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [7:0] len, input logic [3:0] prot, input logic [31:0] seed);
        wr_seed   = seed;
        wr_base   = wr_idx;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_len   = len;
        cmd_prot  = prot;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge hclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!done && n < 100);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        int a0, r0, d0, e0, w0, u0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_len = '0; cmd_prot = '0;
        hresetn = 1'b0;
        step(2);

        // reset state
        chk("rst_htrans", 64'(htrans), 64'h0);
        chk("rst_haddr", 64'(haddr), 64'h0);
        chk("rst_hwrite", 64'(hwrite), 64'h0);
        chk("rst_hsize", 64'(hsize), 64'h0);
        chk("rst_hburst", 64'(hburst), 64'h0);
        chk("rst_hprot", 64'(hprot), 64'h3);
        chk("rst_hwdata", 64'(hwdata), 64'h0);
        chk("rst_flags", 64'({wr_pop, rd_valid, rd_last, done, done_err}), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        hresetn = 1'b1;
        step(2);

        // 1: single read
        issue(1'b0, 32'h10, 3'd2, 8'd0, 4'hA, 32'h0);
        step(1);
        chk("t1_htrans", 64'(htrans), 64'h2);
        chk("t1_haddr", 64'(haddr), 64'h10);
        chk("t1_hburst", 64'(hburst), 64'h0);
        chk("t1_hsize", 64'(hsize), 64'h2);
        chk("t1_hprot", 64'(hprot), 64'hA);
        chk("t1_busy", 64'(cmd_ready), 64'h0);
        step(1);
        chk("t1_idle", 64'(htrans), 64'h0);
        chk("t1_rv_early", 64'(rd_valid), 64'h0);
        step(1);
        chk("t1_rd", 64'({rd_valid, rd_last, done, done_err}), 64'b1110);
        chk("t1_rd_data", 64'(rd_data), 64'h5A00_0010);
        step(1);
        chk("t1_done_pulse", 64'({done, cmd_ready}), 64'b01);

        // 2: write INCR 4 beats
        a0 = acc_addr_q.size(); d0 = done_cnt; e0 = err_cnt; w0 = wr_idx;
        issue(1'b1, 32'h20, 3'd2, 8'd3, 4'h3, 32'hA0);
        step(1);
        chk("t2_hburst", 64'(hburst), 64'h1);
        step(1);
        chk("t2_hwdata0", 64'(hwdata), 64'hA0);
        wait_done("t2", 4);
        chk("t2_done_err", 64'(done_err), 64'h0);
        step(1);
        chk("t2_nacc", 64'(acc_addr_q.size() - a0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_addr", 64'(acc_addr_q[a0 + k]), 64'(32'h20 + 4 * k));
            chk("t2_trans", 64'(acc_trans_q[a0 + k]), (k == 0) ? 64'h2 : 64'h3);
            chk("t2_mem", 64'(mem[8 + k]), 64'(32'hA0 + k));
        end
        chk("t2_pops", 64'(wr_idx - w0), 64'd4);
        chk("t2_ndone", 64'({done_cnt - d0, err_cnt - e0}), {32'd1, 32'd0});

        // 3: read 4 beats, 2 wait states per beat
        ws = 2;
        r0 = rd_q.size(); u0 = unstable_cnt;
        issue(1'b0, 32'h40, 3'd2, 8'd3, 4'h3, 32'h0);
        wait_done("t3", 14);
        chk("t3_last_with_done", 64'({rd_valid, rd_last}), 64'b11);
        step(1);
        ws = 0;
        chk("t3_nrd", 64'(rd_q.size() - r0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_rd_data", 64'(rd_q[r0 + k]), 64'(32'h5A00_0040 + 4 * k));
            chk("t3_rd_last", 64'(rdl_q[r0 + k]), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("t3_stable", 64'(unstable_cnt - u0), 64'd0);

        // 4: ERROR on beat 2 of an 8-beat write
        err_beat = 2;
        a0 = acc_addr_q.size(); e0 = err_cnt; w0 = wr_idx; r0 = rd_q.size();
        issue(1'b1, 32'h100, 3'd2, 8'd7, 4'h3, 32'hB0);
        step(1);
        chk("t4_nonseq", 64'(htrans), 64'h2);
        step(2);
        chk("t4_err1", 64'({htrans, hready, hresp}), {58'd0, 2'b11, 1'b0, 2'b01});
        chk("t4_hwdata1", 64'(hwdata), 64'hB1);
        step(1);
        chk("t4_cancel", 64'({htrans, cmd_ready}), 64'b000);
        step(1);
        chk("t4_done", 64'({done, done_err}), 64'b11);
        step(3);
        err_beat = 0;
        chk("t4_nacc", 64'(acc_addr_q.size() - a0), 64'd2);
        chk("t4_pops", 64'(wr_idx - w0), 64'd2);
        chk("t4_nerr", 64'(err_cnt - e0), 64'd1);
        chk("t4_mem", 64'(mem[64]), 64'hB0);
        chk("t4_nrd", 64'(rd_q.size() - r0), 64'd0);

        // 5: INCR across a 1KB boundary
        a0 = acc_addr_q.size();
        issue(1'b1, 32'h3F8, 3'd2, 8'd3, 4'h3, 32'hC0);
        wait_done("t5", 6);
        step(1);
        chk("t5_nacc", 64'(acc_addr_q.size() - a0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t5_addr", 64'(acc_addr_q[a0 + k]), 64'(32'h3F8 + 4 * k));
            chk("t5_trans", 64'(acc_trans_q[a0 + k]), (k == 0 || k == 2) ? 64'h2 : 64'h3);
        end
        chk("t5_mem", 64'(mem[256]), 64'hC2);

        // oversize command: no bus activity, immediate error completion
        a0 = acc_addr_q.size();
        issue(1'b0, 32'h0, 3'd3, 8'd0, 4'h3, 32'h0);
        step(1);
        chk("ovs_done", 64'({done, done_err, cmd_ready}), 64'b111);
        chk("ovs_htrans", 64'(htrans), 64'h0);
        step(2);
        chk("ovs_nacc", 64'(acc_addr_q.size() - a0), 64'd0);

        // 6: reset mid-burst
        d0 = done_cnt;
        issue(1'b0, 32'h80, 3'd2, 8'd3, 4'h3, 32'h0);
        step(2);
        chk("t6_mid", 64'({htrans, haddr}), {30'd0, 2'b11, 32'h84});
        hresetn = 1'b0;
        #1;
        chk("t6_async_htrans", 64'(htrans), 64'h0);
        chk("t6_async_haddr", 64'(haddr), 64'h0);
        chk("t6_async_hprot", 64'(hprot), 64'h3);
        chk("t6_async_flags", 64'({rd_valid, done, cmd_ready}), 64'b001);
        step(2);
        hresetn = 1'b1;
        step(2);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        issue(1'b0, 32'h80, 3'd2, 8'd1, 4'h3, 32'h0);
        wait_done("t6_post", 4);
        chk("t6_post_rd", 64'({rd_valid, rd_last, done_err}), 64'b110);
        chk("t6_post_data", 64'(rd_data), 64'h5A00_0084);
        step(1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-master AMBA AHB-Lite initiator. Converts simple command requests (read/write, start address, size, beat count) into pipelined NONSEQ/SEQ transfers.
- Sources write data from a show-ahead data stream and returns read data per beat.
- Reports completion and ERROR status per command.
- Sits between local DMA/test logic and the AHB decoder/slave fabric.

Parameters:
AW, 32, address bus width
DW, 32, data bus width (32 or 64)
RW, 2, hresp width
LW, 8, cmd_len width (beats = cmd_len+1)

Ports:
hclk  input  1  bus clock
hresetn  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  high when idle and able to accept a command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  AW  start byte address, aligned to cmd_size
cmd_size  input  3  hsize encoding
cmd_len  input  LW  beats minus one
cmd_prot  input  4  hprot value for whole command
wr_data  input  DW  show-ahead write data; valid whenever wr_pop is high
wr_pop  output  1  consumes one wr_data beat
rd_valid  output  1  read beat valid
rd_data  output  DW  read beat data
rd_last  output  1  final beat of a read command
done  output  1  one-cycle command completion pulse
done_err  output  1  qualifies done: command terminated by ERROR
haddr  output  AW  AHB address
htrans  output  2  AHB transfer type
hwrite  output  1  AHB direction
hsize  output  3  AHB size
hburst  output  3  AHB burst type
hprot  output  4  AHB protection
hwdata  output  DW  AHB write data
hrdata  input  DW  AHB read data
hready  input  1  AHB transfer done
hresp  input  RW  AHB response (OKAY=0, ERROR=1)

Behaviour:
- **Reset values:** all AHB outputs are registered. Reset (async) gives:
  - htrans=IDLE, haddr=0, hwrite=0, hsize=0, hburst=SINGLE, hprot=4'b0011, hwdata=0.
  - wr_pop=0, rd_valid=0, rd_data=0, rd_last=0, done=0, done_err=0.
  - cmd_ready=1 (combinational: state==IDLE).
- **Reset mid-command:** the burst is abandoned, no done is issued, and the state returns to IDLE.
- **States:**
  - IDLE
  - ADDR: address phase pending; covers the first NONSEQ and all subsequent SEQ beats.
  - DATA: last address accepted, waiting for the final data phase.
  - ERR: first ERROR cycle seen, waiting for the second.
- **Accept:**
  - cmd_valid & cmd_ready at edge T.
  - From T+1: NONSEQ with haddr=cmd_addr, hburst=INCR if cmd_len>0, else SINGLE.
  - If cmd_size > log2(DW/8), no bus activity; done=1 and done_err=1 at T+1.
- **Address phase acceptance:** an address phase is accepted on an edge where hready=1 and htrans is NONSEQ or SEQ. After acceptance:
  - Next address = haddr + (1<<hsize), truncated to AW bits.
  - Next htrans = SEQ, or NONSEQ if the next address crosses a 1KB boundary (addr[9:0]==0).
  - After the last beat is accepted, htrans=IDLE and the state moves to DATA.
- **Wait states:** while hready=0, haddr, htrans, hwrite, hsize, hburst and hprot hold stable. BUSY is never driven.
- **Write data:**
  - wr_pop=1 combinationally in any cycle where a write address phase is accepted.
  - wr_data is registered into hwdata at that edge, so hwdata is valid for the whole data phase.
  - hwdata holds while hready=0.
- **Read data:**
  - On each edge where a read data phase completes (hready=1, hresp=OKAY), register rd_data=hrdata and pulse rd_valid next cycle.
  - rd_last accompanies the final beat.
- **Completion:** done pulses one cycle after the final data phase completes with OKAY, coincident with rd_valid/rd_last for reads.
- **Error handling:**
  - Trigger: data phase sees hresp=ERROR with hready=0.
  - Next edge: htrans=IDLE, which cancels any pending address phase; state moves to ERR.
  - Remaining beats are dropped: no further wr_pop or rd_valid, and the errored beat produces no rd_valid.
  - When the second ERROR cycle arrives (hready=1): done=1 and done_err=1 next cycle, then IDLE.
- **Simultaneous events:** cmd_valid during a busy state is ignored (cmd_ready=0). A new command is accepted only in IDLE, so back-to-back commands have at least one IDLE cycle between them.

Decomposition:
- Package ahb_pkg: htrans encodings (IDLE/BUSY/NONSEQ/SEQ), hresp (OKAY/ERROR/RETRY/SPLIT), hburst (SINGLE/INCR/…), hsize encodings, and the state typedef.
- One sub-module, ahb_addr_gen, is natural:
  - Inputs: current address and size.
  - Outputs: next address and a 1KB-crossing flag.
  - Purely combinational.

Test Plan:
1. Single read, zero-wait slave: cmd_addr=0x10, size=2, len=0.
   - NONSEQ/SINGLE at T+1; rd_valid, rd_last and done at T+3; rd_data=mem word at 0x10.
2. Write INCR 4 beats, addr=0x20, size=2, wr_data 0xA0..0xA3.
   - haddr 0x20, 0x24, 0x28, 0x2C with htrans NONSEQ, SEQ, SEQ, SEQ.
   - 4 wr_pop pulses; done once, done_err=0; slave memory holds the data.
3. Read 4 beats against a slave with 2 wait states per beat.
   - Address and control held stable during each hready=0 stretch.
   - 4 rd_valid; done 1 cycle after the last hready=1.
4. Slave ERROR on beat 2 of an 8-beat write.
   - htrans=IDLE the cycle after the first ERROR cycle; wr_pop count=2.
   - done=1 and done_err=1 after the second ERROR cycle; no further NONSEQ/SEQ.
5. INCR crossing a 1KB boundary: addr=0x3F8, size=2, len=3.
   - htrans sequence NONSEQ, SEQ, NONSEQ, SEQ at 0x3F8, 0x3FC, 0x400, 0x404.
6. hresetn low mid-burst (beat 2 of 4).
   - Outputs return to reset values asynchronously; no done.
   - Next command after release completes normally.
